// File: rtl/selftrigger_pkg.sv
// Shared definitions for the baseline-subtracting self-trigger.
// This package holds the trigger FSM state type and the width helpers used
// to size the signed sample path and the baseline accumulator.
package selftrigger_pkg;

  typedef enum logic [2:0] {
    ST_FILL    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_QUAL    = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  // Two guard bits hold the sign and the borrow of an unsigned W-bit difference.
  localparam int Y_GUARD_BITS = 2;

  // The run counter width matches the 4-bit min_width input.
  localparam int RUN_W = 4;

  // Width of the signed baseline-subtracted sample.
  function automatic int y_width(input int w);
    return w + Y_GUARD_BITS;
  endfunction

  // Width of the moving-sum accumulator. It holds 2**log2_depth full-scale samples.
  function automatic int sum_width(input int w, input int log2_depth);
    return w + log2_depth;
  endfunction

endpackage

// File: rtl/param_baseline_selftrigger_movavg.sv
// baseline_movavg: the moving-average baseline over 2**LOG2_DEPTH accepted samples.
// A circular delay line holds the window. The running sum is updated as
// +new - oldest, so the window does not need to be re-summed.
// The clear input restarts only the fill count. The window contents and the
// baseline hold their values, so the output stays meaningful while processing
// is disabled.
module baseline_movavg
  import selftrigger_pkg::*;
#(
  parameter int W          = 14,
  parameter int LOG2_DEPTH = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         accept,
  input  logic [W-1:0] x,
  output logic [W-1:0] baseline,
  output logic         filled
);

  localparam int DEPTH = 2 ** LOG2_DEPTH;
  localparam int SUM_W = sum_width(W, LOG2_DEPTH);
  localparam logic [LOG2_DEPTH:0] FULL_CNT = (LOG2_DEPTH + 1)'(DEPTH);

  logic [W-1:0]          dl_r [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_r;
  logic [SUM_W-1:0]      acc_r;
  logic [W-1:0]          baseline_r;
  logic [LOG2_DEPTH:0]   fill_cnt_r;
  logic [SUM_W-1:0]      next_acc_s;

  // Next running sum if the current sample is accepted: add the new sample and drop the oldest.
  always_comb begin
    next_acc_s = acc_r + {{LOG2_DEPTH{1'b0}}, x} - {{LOG2_DEPTH{1'b0}}, dl_r[wr_ptr_r]};
  end

  // Window, sum and baseline advance only on accepted samples. Fill counting saturates at the window size.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        dl_r[i] <= {W{1'b0}};
      end
      wr_ptr_r   <= {LOG2_DEPTH{1'b0}};
      acc_r      <= {SUM_W{1'b0}};
      baseline_r <= {W{1'b0}};
      fill_cnt_r <= {(LOG2_DEPTH + 1){1'b0}};
    end else begin
      if (accept) begin
        dl_r[wr_ptr_r] <= x;
        wr_ptr_r       <= wr_ptr_r + {{(LOG2_DEPTH - 1){1'b0}}, 1'b1};
        acc_r          <= next_acc_s;
        baseline_r     <= next_acc_s[SUM_W-1:LOG2_DEPTH];
      end
      if (clear) begin
        fill_cnt_r <= {(LOG2_DEPTH + 1){1'b0}};
      end else if (accept && (fill_cnt_r != FULL_CNT)) begin
        fill_cnt_r <= fill_cnt_r + {{LOG2_DEPTH{1'b0}}, 1'b1};
      end
    end
  end

  assign baseline = baseline_r;
  assign filled   = (fill_cnt_r == FULL_CNT);

endmodule

// File: rtl/param_baseline_selftrigger.sv
// param_baseline_selftrigger: a moving-average baseline subtractor with a
// threshold/hysteresis self-trigger. The trigger needs a minimum pulse width
// and has a holdoff period after each pulse.
// Build option PEAK_CAPTURE_EN adds capture of the peak value of each pulse.
// Without this option, peak and peak_valid are tied to 0.
// The sample pipeline is: x_r (registered input), then y_r (baseline
// subtracted), then the FSM decision. Each sample is offered to the baseline
// when the FSM judges its y. A sample that starts or continues a pulse
// therefore never enters the baseline.
module param_baseline_selftrigger
  import selftrigger_pkg::*;
#(
  parameter int W          = 14,
  parameter int LOG2_DEPTH = 5,
  parameter int HOLDOFF_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 invert_enable,
  input  logic [W-1:0]         threshold,
  input  logic [W-1:0]         hysteresis,
  input  logic [3:0]           min_width,
  input  logic [HOLDOFF_W-1:0] holdoff,
  input  logic [W-1:0]         x,
  output logic [W-1:0]         baseline,
  output logic signed [W+1:0]  y,
  output logic                 trigger,
  output logic                 trigger_active,
  output logic signed [W+1:0]  peak,
  output logic                 peak_valid
);

  localparam int YW = y_width(W);

  logic [W-1:0]          x_r;
  logic [W-1:0]          x_d_r;
  logic                  x_vld_r;
  logic                  y_vld_r;
  logic signed [YW-1:0]  y_r;
  state_e                state_r;
  logic [RUN_W-1:0]      run_cnt_r;
  logic [HOLDOFF_W-1:0]  hold_cnt_r;
  logic                  trigger_r;
  logic                  trig_act_r;

  logic signed [YW-1:0]  thr_s;
  logic signed [YW-1:0]  rel_s;
  logic signed [YW-1:0]  diff_s;
  logic                  over_thr_s;
  logic                  stay_active_s;
  logic                  accept_s;
  logic                  filled_s;
  logic [RUN_W-1:0]      min_eff_s;
  logic [RUN_W:0]        run_next_s;

  // Signed thresholds, the baseline-subtracted difference, and the comparisons made on the current y.
  always_comb begin
    thr_s         = signed'({2'b00, threshold});
    rel_s         = thr_s - signed'({2'b00, hysteresis});
    diff_s        = invert_enable ? signed'({2'b00, baseline} - {2'b00, x_r})
                                  : signed'({2'b00, x_r} - {2'b00, baseline});
    over_thr_s    = (y_r > thr_s);
    stay_active_s = (y_r > rel_s);
    min_eff_s     = (min_width == 4'd0) ? 4'd1 : min_width;
    run_next_s    = {1'b0, run_cnt_r} + 5'd1;
  end

  // Baseline intake: every valid sample while filling, and quiet samples only while idle.
  always_comb begin
    accept_s = 1'b0;
    if (enable && y_vld_r) begin
      if (state_r == ST_FILL) begin
        accept_s = 1'b1;
      end else if ((state_r == ST_IDLE) && !over_thr_s) begin
        accept_s = 1'b1;
      end else begin
        accept_s = 1'b0;
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  baseline_movavg #(
    .W          (W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_movavg (
    .clk      (clk),
    .reset    (reset),
    .clear    (~enable),
    .accept   (accept_s),
    .x        (x_d_r),
    .baseline (baseline),
    .filled   (filled_s)
  );

  // Sample pipeline: register x, then subtract the baseline. y reads 0 until a real sample reaches it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r     <= {W{1'b0}};
      x_d_r   <= {W{1'b0}};
      x_vld_r <= 1'b0;
      y_vld_r <= 1'b0;
      y_r     <= {YW{1'b0}};
    end else if (!enable) begin
      x_vld_r <= 1'b0;
      y_vld_r <= 1'b0;
      y_r     <= {YW{1'b0}};
    end else begin
      x_r     <= x;
      x_vld_r <= 1'b1;
      x_d_r   <= x_r;
      y_vld_r <= x_vld_r;
      y_r     <= x_vld_r ? diff_s : {YW{1'b0}};
    end
  end

  // Trigger FSM with registered trigger and trigger_active. Holdoff lasts max(holdoff,1) cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_FILL;
      run_cnt_r  <= {RUN_W{1'b0}};
      hold_cnt_r <= {HOLDOFF_W{1'b0}};
      trigger_r  <= 1'b0;
      trig_act_r <= 1'b0;
    end else if (!enable) begin
      state_r    <= ST_FILL;
      run_cnt_r  <= {RUN_W{1'b0}};
      hold_cnt_r <= {HOLDOFF_W{1'b0}};
      trigger_r  <= 1'b0;
      trig_act_r <= 1'b0;
    end else begin
      trigger_r <= 1'b0;
      case (state_r)
        ST_FILL: begin
          trig_act_r <= 1'b0;
          if (filled_s) begin
            state_r <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (y_vld_r && over_thr_s) begin
            run_cnt_r  <= 4'd1;
            trig_act_r <= 1'b1;
            if (min_eff_s == 4'd1) begin
              trigger_r <= 1'b1;
              state_r   <= ST_ACTIVE;
            end else begin
              state_r <= ST_QUAL;
            end
          end else begin
            trig_act_r <= 1'b0;
          end
        end
        ST_QUAL: begin
          if (over_thr_s) begin
            run_cnt_r <= run_next_s[RUN_W-1:0];
            if (run_next_s >= {1'b0, min_eff_s}) begin
              trigger_r <= 1'b1;
              state_r   <= ST_ACTIVE;
            end
          end else begin
            trig_act_r <= 1'b0;
            state_r    <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (!stay_active_s) begin
            hold_cnt_r <= holdoff;
            state_r    <= ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt_r <= {{(HOLDOFF_W - 1){1'b0}}, 1'b1}) begin
            trig_act_r <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            hold_cnt_r <= hold_cnt_r - {{(HOLDOFF_W - 1){1'b0}}, 1'b1};
          end
        end
        default: begin
          trig_act_r <= 1'b0;
          state_r    <= ST_FILL;
        end
      endcase
    end
  end

  assign y              = y_r;
  assign trigger        = trigger_r;
  assign trigger_active = trig_act_r;

`ifdef PEAK_CAPTURE_EN
  logic signed [YW-1:0] peak_r;
  logic                 peak_valid_r;

  // Peak tracking: load on pulse entry, track the maximum while qualifying or active, strobe on release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_r       <= {YW{1'b0}};
      peak_valid_r <= 1'b0;
    end else begin
      peak_valid_r <= 1'b0;
      if (enable) begin
        case (state_r)
          ST_IDLE: begin
            if (y_vld_r && over_thr_s) begin
              peak_r <= y_r;
            end
          end
          ST_QUAL: begin
            if (over_thr_s && (y_r > peak_r)) begin
              peak_r <= y_r;
            end
          end
          ST_ACTIVE: begin
            if (stay_active_s) begin
              if (y_r > peak_r) begin
                peak_r <= y_r;
              end
            end else begin
              peak_valid_r <= 1'b1;
            end
          end
          default: begin
            peak_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign peak       = peak_r;
  assign peak_valid = peak_valid_r;
`else
  assign peak       = {YW{1'b0}};
  assign peak_valid = 1'b0;
`endif

endmodule

// File: tb/tb_param_baseline_selftrigger.sv
// Testbench for param_baseline_selftrigger (W=14, LOG2_DEPTH=5).
// A sample-level reference model works from the behavioural rules. It keeps a
// list of accepted samples, a mean over that list, a pulse phase and
// countdowns, and from these it predicts every output after every clock.
// Directed scenarios and a randomized pulse phase drive the inputs. Each
// directed scenario also has explicit constant checks.
module tb_param_baseline_selftrigger;

  localparam int P_FILL = 0, P_IDLE = 1, P_QUAL = 2, P_ACT = 3, P_HOLD = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic               invert_enable = 1'b0;
  logic [13:0]        threshold = 14'd100;
  logic [13:0]        hysteresis = 14'd50;
  logic [3:0]         min_width = 4'd1;
  logic [7:0]         holdoff = 8'd10;
  logic [13:0]        x = 14'd0;
  logic [13:0]        baseline;
  logic signed [15:0] y;
  logic               trigger;
  logic               trigger_active;
  logic signed [15:0] peak;
  logic               peak_valid;

  int total = 0;
  int bad = 0;
  int trig_cnt, act_cnt, pv_cnt, pk_seen;

  // reference model state
  int m_hist[$];
  int m_fill, m_phase, m_run, m_hold, m_y, m_xprev, m_xdec, m_peak;
  bit m_have_x, m_have_y;
  int e_trig, e_act, e_pv;

  param_baseline_selftrigger #(.W(14), .LOG2_DEPTH(5), .HOLDOFF_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .invert_enable(invert_enable),
    .threshold(threshold), .hysteresis(hysteresis), .min_width(min_width),
    .holdoff(holdoff), .x(x), .baseline(baseline), .y(y), .trigger(trigger),
    .trigger_active(trigger_active), .peak(peak), .peak_valid(peak_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_base();
    int s = 0;
    foreach (m_hist[i]) s += m_hist[i];
    return s / 32;
  endfunction

  task automatic m_reset();
    m_hist.delete();
    repeat (32) m_hist.push_back(0);
    m_fill = 0; m_phase = P_FILL; m_run = 0; m_hold = 0;
    m_y = 0; m_xprev = 0; m_xdec = 0; m_peak = 0;
    m_have_x = 0; m_have_y = 0;
    e_trig = 0; e_act = 0; e_pv = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs present at that edge.
  task automatic m_edge();
    int ob, ny, thr, rel, eff;
    bit acc;
    e_trig = 0; e_pv = 0;
    if (!enable) begin
      m_have_x = 0; m_have_y = 0; m_y = 0;
      m_phase = P_FILL; m_fill = 0; e_act = 0;
      return;
    end
    ob  = m_base();
    thr = int'(threshold);
    rel = thr - int'(hysteresis);
    eff = (min_width == 4'd0) ? 1 : int'(min_width);
    ny  = m_have_x ? (invert_enable ? ob - m_xprev : m_xprev - ob) : 0;
    acc = 0;
    case (m_phase)
      P_FILL: begin
        if (m_fill >= 32) m_phase = P_IDLE;
        if (m_have_y) acc = 1;
      end
      P_IDLE: begin
        if (m_have_y && m_y > thr) begin
          m_run = 1; m_peak = m_y;
          if (eff <= 1) begin m_phase = P_ACT; e_trig = 1; end
          else m_phase = P_QUAL;
        end else if (m_have_y) acc = 1;
      end
      P_QUAL: begin
        if (m_y > thr) begin
          m_run++;
          if (m_y > m_peak) m_peak = m_y;
          if (m_run >= eff) begin m_phase = P_ACT; e_trig = 1; end
        end else m_phase = P_IDLE;
      end
      P_ACT: begin
        if (m_y > rel) begin
          if (m_y > m_peak) m_peak = m_y;
        end else begin
          m_phase = P_HOLD; e_pv = 1;
          m_hold = (holdoff == 8'd0) ? 1 : int'(holdoff);
        end
      end
      default: begin
        m_hold--;
        if (m_hold == 0) m_phase = P_IDLE;
      end
    endcase
    if (acc) begin
      m_hist.push_back(m_xdec);
      void'(m_hist.pop_front());
      if (m_fill < 32) m_fill++;
    end
    m_y = ny; m_have_y = m_have_x;
    m_xdec = m_xprev; m_xprev = int'(x); m_have_x = 1;
    e_act = (m_phase == P_QUAL || m_phase == P_ACT || m_phase == P_HOLD) ? 1 : 0;
  endtask

  task automatic check_all();
    chk("baseline", baseline, m_base());
    chk("y", y, m_y);
    chk("trigger", trigger, e_trig);
    chk("trigger_active", trigger_active, e_act);
`ifdef PEAK_CAPTURE_EN
    chk("peak", peak, m_peak);
    chk("peak_valid", peak_valid, e_pv);
`else
    chk("peak", peak, 0);
    chk("peak_valid", peak_valid, 0);
`endif
    if (trigger) trig_cnt++;
    if (trigger_active) act_cnt++;
    if (peak_valid) begin pv_cnt++; pk_seen = int'(peak); end
  endtask

  task automatic step(input int xv);
    x = xv[13:0];
    @(posedge clk);
    m_edge();
    #1;
    check_all();
  endtask

  task automatic hit_reset();
    reset = 1'b1;
    #1;
    m_reset();
    check_all();
    chk("rst_y", y, 0);
    chk("rst_trig_active", trigger_active, 0);
    chk("rst_peak_valid", peak_valid, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all();
    end
    reset = 1'b0;
  endtask

  task automatic clr_cnt();
    trig_cnt = 0; act_cnt = 0; pv_cnt = 0; pk_seen = 0;
  endtask

  function automatic int noise();
    int n = int'($urandom_range(0, 16));
    return 7992 + n;
  endfunction

  initial begin
    int amp, wid;
    bit inv;
    clr_cnt();
    // reset state
    hit_reset();
    enable = 1'b1;

    // fill: baseline averages 32 samples including one 16000 spike, then settles
    clr_cnt();
    for (int i = 1; i <= 66; i++) begin
      step((i == 11) ? 16000 : 8000);
      if (i == 34) begin
        chk("fill_base_8250", baseline, 8250);
        chk("fill_no_trigger", trig_cnt, 0);
      end
    end
    chk("fill_base_8000", baseline, 8000);

    // single pulse: y at +2, trigger at +3, trigger_active for 11 cycles, and a retrigger during holdoff ignored
    clr_cnt();
    step(8200);
    step(8000);
    chk("single_y_200", y, 200);
    step(8000);
    chk("single_trigger_lat", trigger, 1);
    step(8000); step(8000);
    step(8200);
    repeat (20) step(8000);
    chk("single_trig_cnt", trig_cnt, 1);
    chk("single_active_len", act_cnt, 11);
    chk("single_base_kept", baseline, 8000);

    // width qualification
    min_width = 4'd3;
    clr_cnt();
    step(8200); step(8200);
    repeat (10) step(8000);
    chk("qual2_no_trigger", trig_cnt, 0);
    chk("qual2_active_len", act_cnt, 2);
    step(8200); step(8200); step(8200);
    step(8000);
    chk("qual3_y_third", y, 200);
    chk("qual3_not_yet", trigger, 0);
    step(8000);
    chk("qual3_trigger", trigger, 1);
    repeat (20) step(8000);
    chk("qual3_trig_cnt", trig_cnt, 1);

    // hysteresis and peak
    min_width = 4'd1;
    clr_cnt();
    step(8200); step(8080); step(8060); step(8040);
    repeat (15) step(8000);
    chk("hyst_trig_cnt", trig_cnt, 1);
    chk("hyst_active_len", act_cnt, 13);
`ifdef PEAK_CAPTURE_EN
    chk("hyst_pv_cnt", pv_cnt, 1);
    chk("hyst_peak", pk_seen, 200);
`else
    chk("hyst_pv_cnt", pv_cnt, 0);
`endif

    // inversion
    invert_enable = 1'b1;
    clr_cnt();
    step(7800);
    step(8000);
    chk("inv_y_200", y, 200);
    repeat (15) step(8000);
    chk("inv_trig_cnt", trig_cnt, 1);
    chk("inv_base_kept", baseline, 8000);
    invert_enable = 1'b0;

    // disable holds the baseline and forces y/trigger low; refill after re-enable suppresses triggers
    enable = 1'b0;
    clr_cnt();
    for (int i = 0; i < 4; i++) begin
      step(9000 + i * 100);
      chk("dis_y", y, 0);
      chk("dis_base", baseline, 8000);
    end
    enable = 1'b1;
    for (int i = 1; i <= 34; i++) step((i == 5) ? 8600 : 8000);
    chk("refill_no_trigger", trig_cnt, 0);
    repeat (40) step(8000);

    // randomized pulses on a noisy baseline with live parameter changes
    for (int p = 0; p < 24; p++) begin
      threshold  = 14'(100 + $urandom_range(0, 50));
      hysteresis = 14'($urandom_range(0, 80));
      min_width  = 4'($urandom_range(0, 3));
      holdoff    = 8'($urandom_range(0, 6));
      inv        = 1'($urandom_range(0, 1));
      invert_enable = inv;
      amp = int'($urandom_range(50, 400));
      wid = int'($urandom_range(1, 5));
      for (int w = 0; w < wid; w++) step(inv ? 8000 - amp : 8000 + amp);
      repeat (20) step(noise());
    end

    // reset during a pulse aborts it, and 32 samples are then needed before a trigger
    invert_enable = 1'b0;
    threshold = 14'd100; hysteresis = 14'd50; min_width = 4'd1; holdoff = 8'd10;
    repeat (40) step(8000);
    clr_cnt();
    repeat (4) step(8500);
    chk("rst_pulse_active", trigger_active, 1);
    hit_reset();
    chk("rst_base_zero", baseline, 0);
    clr_cnt();
    repeat (34) step(8000);
    chk("rst_refill_no_trig", trig_cnt, 0);
    chk("rst_refill_no_pv", pv_cnt, 0);
    step(8200);
    repeat (5) step(8000);
    chk("rst_after_trigger", trig_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute time bound so the run always terminates
  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
